// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and FSM state encoding for the in-place memory sorter.
package sort_pkg;
    localparam int MEM_DEPTH = 1024;
    localparam int IDX_W     = 10;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_A     = 3'd1,
        S_RD_B     = 3'd2,
        S_CMP      = 3'd3,
        S_WR_A     = 3'd4,
        S_WR_B     = 3'd5,
        S_PASS_END = 3'd6,
        S_DONE     = 3'd7
    } sort_state_t;
endpackage

// File: rtl/sort_cmp.sv
// sort_cmp: swap decision for one adjacent pair; SORT_DESC_EN selects descending order.
// Equal words never swap, which keeps the sort stable in both orders.
module sort_cmp import sort_pkg::*; #(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         swap_o
);
`ifdef SORT_DESC_EN
    assign swap_o = a_i < b_i;
`else
    assign swap_o = a_i > b_i;
`endif
endmodule

// File: rtl/mem_sort_ctrl.sv
// mem_sort_ctrl: in-place bubble-sort sequencer for a 1024x32 single-port memory.
// Order is set by SORT_DESC_EN inside sort_cmp (undefined: ascending).
module mem_sort_ctrl import sort_pkg::*; #(
    parameter int DATA_W = sort_pkg::DATA_W,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = sort_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  base,
    input  logic [IDX_W:0]    len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_wr_en,
    output logic              mem_rd_en
);
    localparam logic [IDX_W:0] LEN_MAX = {1'b1, {IDX_W{1'b0}}};

    sort_state_t       state_q, state_d;
    logic [IDX_W-1:0]  base_q, base_d, last_q, last_d, i_q, i_d, i_nx, idx;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              swapped_q, swapped_d, err_q, err_d, swap;

    sort_cmp #(.W(DATA_W)) u_cmp (.a_i(a_q), .b_i(mem_dout), .swap_o(swap));

    assign i_nx = i_q + IDX_W'(1);
    // the upper word of the pair sits one index above i; IDX_W-bit sums wrap the region
    assign idx  = base_q + i_q + IDX_W'(state_q == S_RD_B || state_q == S_WR_B);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        last_d    = last_q;
        i_d       = i_q;
        a_d       = a_q;
        b_d       = b_q;
        swapped_d = swapped_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                if (len > LEN_MAX) err_d = 1'b1;
                else if (len < (IDX_W+1)'(2)) state_d = S_DONE;
                else begin
                    base_d    = base;
                    last_d    = IDX_W'(len - (IDX_W+1)'(1));
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = S_RD_A;
                end
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: begin
                a_d     = mem_dout;
                state_d = S_CMP;
            end
            S_CMP: begin
                b_d = mem_dout;
                if (swap) state_d = S_WR_A;
                else begin
                    i_d     = i_nx;
                    state_d = (i_nx < last_q) ? S_RD_A : S_PASS_END;
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: begin
                swapped_d = 1'b1;
                i_d       = i_nx;
                state_d   = (i_nx < last_q) ? S_RD_A : S_PASS_END;
            end
            S_PASS_END: if (!swapped_q || last_q == IDX_W'(1)) state_d = S_DONE;
            else begin
                last_d    = last_q - IDX_W'(1);
                i_d       = '0;
                swapped_d = 1'b0;
                state_d   = S_RD_A;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            last_q    <= '0;
            i_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            last_q    <= last_d;
            i_q       <= i_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
            err_q     <= err_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign err       = err_q;
    assign mem_rd_en = state_q == S_RD_A || state_q == S_RD_B;
    assign mem_wr_en = state_q == S_WR_A || state_q == S_WR_B;
    assign mem_adr   = (mem_rd_en || mem_wr_en) ? ADDR_W'(idx) : '0;
    assign mem_din   = state_q == S_WR_A ? b_q : state_q == S_WR_B ? a_q : '0;
endmodule

// File: tb/tb_mem_sort_ctrl.sv
// tb_mem_sort_ctrl: directed and randomized checks of mem_sort_ctrl against an array-based sort model.
module tb_mem_sort_ctrl;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy, done, err, mem_wr_en, mem_rd_en;
    logic [31:0] mem_adr, mem_din, mem_dout;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, hi_cnt = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_sort_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .err(err),
        .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en)
    );

    // single-port memory: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_dout = mem[mem_adr[9:0]];
            rd_cnt   = rd_cnt + 1;
        end
        if (mem_wr_en) begin
            mem[mem_adr[9:0]] = mem_din;
            wr_cnt = wr_cnt + 1;
        end
        if (mem_rd_en && mem_wr_en) both_cnt = both_cnt + 1;
        if ((mem_rd_en || mem_wr_en) && mem_adr[31:10] != 22'd0) hi_cnt = hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int a, input logic [31:0] v);
        mem[a % 1024]     = v;
        ref_mem[a % 1024] = v;
    endtask

    function automatic bit out_of_order(input logic [31:0] a, input logic [31:0] b);
`ifdef SORT_DESC_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // early-exit bubble sort over ref_mem; cyc = edges from launch edge to done
    task automatic model_sort(input int b, input int n, output int cyc, output int swaps);
        int last = n - 1;
        cyc   = 1;
        swaps = 0;
        if (n <= 1) return;
        forever begin
            bit sw;
            sw = 0;
            for (int i = 0; i < last; i++) begin
                int p, q;
                logic [31:0] t;
                p = (b + i) % 1024;
                q = (b + i + 1) % 1024;
                cyc += 3;
                if (out_of_order(ref_mem[p], ref_mem[q])) begin
                    t = ref_mem[p]; ref_mem[p] = ref_mem[q]; ref_mem[q] = t;
                    cyc += 2;
                    swaps++;
                    sw = 1;
                end
            end
            cyc += 1;
            if (!sw || last == 1) break;
            last--;
        end
    endtask

    task automatic sort_case(input string tag, input int b, input int l, input int poke);
        int exp_cyc = 0, exp_sw = 0, w0, r0, done_at = 0, err_at = 0, bad = 0, lim;
        bit rej;
        rej = l > 1024;
        if (!rej) model_sort(b, l, exp_cyc, exp_sw);
        lim = rej ? 20 : exp_cyc + 20;
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(posedge clk); #1;
        base  = 10'(b);
        len   = 11'(l);
        start = 1'b1;
        for (int c = 1; c <= lim; c++) begin
            @(posedge clk); #1;
            start = (c == poke);
            if (c == poke) begin
                base = 10'(b + 3);
                len  = 11'd2;
            end
            if (err && err_at == 0) err_at = c;
            if (done) begin
                done_at = c;
                check($sformatf("%s busy_at_done", tag), busy, 1);
                break;
            end
        end
        start = 1'b0;
        if (rej) begin
            check($sformatf("%s err_cycle", tag), err_at, 1);
            check($sformatf("%s no_done", tag), done_at, 0);
            check($sformatf("%s writes", tag), wr_cnt - w0, 0);
        end else begin
            check($sformatf("%s done_cycle", tag), done_at, exp_cyc);
            check($sformatf("%s writes", tag), wr_cnt - w0, 2 * exp_sw);
            check($sformatf("%s no_err", tag), err_at, 0);
            @(posedge clk); #1;
            check($sformatf("%s done_one_cycle", tag), done, 0);
            check($sformatf("%s idle_after", tag), busy, 0);
        end
        if (l <= 1 || rej) check($sformatf("%s no_reads", tag), rd_cnt - r0, 0);
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check($sformatf("%s mem_bad_words", tag), bad, 0);
    endtask

    initial begin
        bit seen = 0;
        int w;
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        for (int i = 0; i < 1024; i++) put(i, $urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst wr_en", mem_wr_en, 0);
        check("rst rd_en", mem_rd_en, 0);
        check("rst adr", mem_adr, 0);
        check("rst din", mem_din, 0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) put(k, 32'(k + 1));
        sort_case("presorted", 0, 4, 0);

        put(7, 32'd777);
        put(13, 32'd1313);
        for (int k = 0; k < 5; k++) put(8 + k, 32'(5 - k));
        sort_case("reverse", 8, 5, 0);
        check("reverse mem7", mem[7], 777);
        check("reverse mem13", mem[13], 1313);

        put(1022, 9); put(1023, 7); put(0, 3); put(1, 1);
        sort_case("wrap", 1022, 4, 0);

        put(20, 2); put(21, 2); put(22, 1);
        sort_case("ties", 20, 3, 0);

        put(30, 5); put(31, 4);
        sort_case("len0", 30, 0, 0);
        sort_case("len1", 30, 1, 0);
        sort_case("len1025", 30, 1025, 0);

        put(50, 1); put(51, 3); put(52, 2);
        sort_case("three", 50, 3, 0);

        for (int k = 0; k < 6; k++) put(40 + k, $urandom_range(0, 9));
        sort_case("start_busy", 40, 6, 5);

        for (int r = 0; r < 10; r++) begin
            int b, n;
            b = $urandom_range(0, 1023);
            n = $urandom_range(2, 12);
            for (int k = 0; k < n; k++) put(b + k, (r % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom);
            sort_case($sformatf("rand%0d", r), b, n, (r == 3) ? 4 : 0);
        end

        for (int k = 0; k < 6; k++) put(100 + k, 32'(60 - 10 * k));
        @(posedge clk); #1;
        base  = 10'd100;
        len   = 11'd6;
        start = 1'b1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mem_wr_en) seen = 1;
        end
        check("rst_mid reached_wr_a", seen, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid busy", busy, 0);
        check("rst_mid wr_en", mem_wr_en, 0);
        check("rst_mid rd_en", mem_rd_en, 0);
        w = wr_cnt;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid no_writes", wr_cnt - w, 0);
        check("rst_mid stays_idle", busy, 0);

        check("rd_wr_overlap", both_cnt, 0);
        check("adr_high_bits", hi_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
